delta_decode_sequencer: RTL

Sequences the 1-bit delta-modulation decode datapath. Accepts packed 8-bit encoded bytes over a valid/ready handshake and buffers one byte ahead. Serialises the bits MSB-first, one bit per sample tick, and keeps the running sample accumulator itself, so the previous-output feedback is internal. Sits between the encoded-byte source (UART/BRAM reader) and the audio output stage (PWM/DAC).

---
 rtl/delta_decode_sequencer_pkg.sv | 26 ++
 rtl/delta_decode_sequencer_sample_tick_gen.sv | 30 +++
 rtl/delta_decode_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/delta_decode_sequencer_pkg.sv
// Shared types and constants for the 1-bit delta-modulation decode sequencer.
package delta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int          DEF_STEP       = 10;
    localparam int unsigned DEF_SAMPLE_DIV = 12500;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned TICK_CNT_W     = 16;

    function automatic int sample_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sample_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAMPLE_MAX = sample_max(DEF_DATA_W);
    localparam int SAMPLE_MIN = sample_min(DEF_DATA_W);

endpackage

// File: rtl/delta_decode_sequencer_sample_tick_gen.sv
// Sample-rate divider: tick is high on the last cycle of each SAMPLE_DIV period while run=1.
module sample_tick_gen
    import delta_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic CLK100MHZ,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(SAMPLE_DIV - 1);

    logic [TICK_CNT_W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/delta_decode_sequencer.sv
// Delta-modulation decode sequencer: byte prefetch, MSB-first bit serialiser and sample accumulator.
// Define DELTA_SAT_EN to clamp the accumulator instead of wrapping it.
module delta_decode_sequencer
    import delta_pkg::*;
#(
    parameter int          STEP       = DEF_STEP,
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned DATA_W     = DEF_DATA_W
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned SUM_W = DATA_W + 1;
    localparam logic signed [SUM_W-1:0] STEP_EXT = SUM_W'(STEP);
`ifdef DELTA_SAT_EN
    localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(sample_max(DATA_W));
    localparam logic signed [SUM_W-1:0] MIN_EXT = SUM_W'(sample_min(DATA_W));
`endif

    state_t            state, state_next;
    logic [7:0]        shreg, shreg_next;
    logic [3:0]        rem, rem_next;
    logic [7:0]        pbuf, pbuf_next;
    logic              pbuf_full, pbuf_full_next;
    logic [DATA_W-1:0] acc, acc_next;
    logic [DATA_W-1:0] sample_out_next;
    logic              sample_valid_next;
    logic              underrun_next;
    logic              byte_ready_next;
    logic              busy_next;
    logic              tick;

    logic                    step_bit;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] sum;
    logic [DATA_W-1:0]       acc_step;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .CLK100MHZ(CLK100MHZ),
        .reset_n  (reset_n),
        .clear    (state == IDLE),
        .run      (state == RUN),
        .tick     (tick)
    );

    // Next accumulator value for the bit about to be popped (shift reg, else the buffer head).
    always_comb begin
        step_bit = (rem != 4'd0) ? shreg[7] : pbuf[7];
        acc_ext  = {acc[DATA_W-1], acc};
        sum      = step_bit ? (acc_ext + STEP_EXT) : (acc_ext - STEP_EXT);
        acc_step = sum[DATA_W-1:0];
`ifdef DELTA_SAT_EN
        if (sum > MAX_EXT) begin
            acc_step = MAX_EXT[DATA_W-1:0];
        end else if (sum < MIN_EXT) begin
            acc_step = MIN_EXT[DATA_W-1:0];
        end
`endif
    end

    always_comb begin
        state_next        = state;
        shreg_next        = shreg;
        rem_next          = rem;
        pbuf_next         = pbuf;
        pbuf_full_next    = pbuf_full;
        acc_next          = acc;
        sample_out_next   = sample_out;
        sample_valid_next = 1'b0;
        underrun_next     = underrun;

        if (!enable) begin
            state_next     = IDLE;
            shreg_next     = '0;
            rem_next       = '0;
            pbuf_full_next = 1'b0;
            underrun_next  = 1'b0;
            acc_next       = '0;
        end else begin
            case (state)
                IDLE: begin
                    acc_next   = '0;
                    state_next = PRIME;
                end
                PRIME:   if (rem != 4'd0) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase

            // A tick pops from the shift reg, or straight from the buffer when a reload is due.
            if (state == RUN && tick) begin
                if (rem != 4'd0) begin
                    shreg_next        = {shreg[6:0], 1'b0};
                    rem_next          = rem - 4'd1;
                    acc_next          = acc_step;
                    sample_out_next   = acc_step;
                    sample_valid_next = 1'b1;
                end else if (pbuf_full) begin
                    shreg_next        = {pbuf[6:0], 1'b0};
                    rem_next          = 4'd7;
                    pbuf_full_next    = 1'b0;
                    acc_next          = acc_step;
                    sample_out_next   = acc_step;
                    sample_valid_next = 1'b1;
                end else begin
                    underrun_next     = 1'b1;
                    sample_valid_next = 1'b1;
                end
            end else if (state != IDLE && rem == 4'd0 && pbuf_full) begin
                shreg_next     = pbuf;
                rem_next       = 4'd8;
                pbuf_full_next = 1'b0;
            end

            if (byte_valid && byte_ready) begin
                pbuf_next      = byte_data;
                pbuf_full_next = 1'b1;
            end
        end

        byte_ready_next = (state_next != IDLE) && !pbuf_full_next;
        busy_next       = (state_next != IDLE);
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            rem          <= '0;
            pbuf         <= '0;
            pbuf_full    <= 1'b0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            byte_ready   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            shreg        <= shreg_next;
            rem          <= rem_next;
            pbuf         <= pbuf_next;
            pbuf_full    <= pbuf_full_next;
            acc          <= acc_next;
            sample_out   <= sample_out_next;
            sample_valid <= sample_valid_next;
            underrun     <= underrun_next;
            byte_ready   <= byte_ready_next;
            busy         <= busy_next;
        end
    end

endmodule
